// File: rtl/rifl_pkg.sv
// Shared RIFL receive-side definitions: sync header codes and lock FSM state encoding.
package rifl_pkg;

    localparam logic [1:0] RIFL_HDR_DATA = 2'b01;
    localparam logic [1:0] RIFL_HDR_CTRL = 2'b10;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SLIP   = 2'd1,
        ST_LOCKED = 2'd2
    } lock_state_t;

    function automatic logic hdr_is_valid(input logic [1:0] hdr);
        return (hdr == RIFL_HDR_DATA) || (hdr == RIFL_HDR_CTRL);
    endfunction

endpackage

// File: rtl/rifl_rx_err_filter.sv
// CRC error hysteresis: one bad CRC raises rx_error, a run of good CRCs clears it.
module rifl_rx_err_filter #(
    parameter int ERR_CLEAR_CNT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic crc_valid,
    input  logic crc_good,
    output logic rx_error
);

    localparam int OW = $clog2(ERR_CLEAR_CNT + 1);
    localparam logic [OW-1:0] OK_LAST = OW'(ERR_CLEAR_CNT - 1);

    logic [OW-1:0] ok_cnt;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            rx_error <= 1'b0;
            ok_cnt   <= '0;
        end else if (crc_valid) begin
            if (!crc_good) begin
                rx_error <= 1'b1;
                ok_cnt   <= '0;
            end else if (rx_error) begin
                if (ok_cnt == OK_LAST) begin
                    rx_error <= 1'b0;
                    ok_cnt   <= '0;
                end else begin
                    ok_cnt <= ok_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rifl_rx_lock.sv
// Receive frame lock: hunts for sync-header alignment via gearbox slips, then monitors
// header health per window and filters CRC results into a level error flag.
//
// state  | meaning
// HUNT   | counting consecutive valid headers toward lock
// SLIP   | slip issued, waiting SLIP_WAIT cycles for the gearbox to settle
// LOCKED | aligned; rx_up high, bad headers tracked per WINDOW frames
module rifl_rx_lock
    import rifl_pkg::*;
#(
    parameter int LOCK_CNT      = 64,
    parameter int WINDOW        = 64,
    parameter int BAD_THRESH    = 16,
    parameter int SLIP_WAIT     = 32,
    parameter int ERR_CLEAR_CNT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [1:0] rx_hdr,
    input  logic       rx_crc_valid,
    input  logic       rx_crc_good,
    output logic       rx_slip,
    output logic       rx_up,
    output logic       rx_error
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int BW = $clog2(BAD_THRESH + 1);
    localparam int SW = $clog2(SLIP_WAIT + 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(BAD_THRESH - 1);
    localparam logic [SW-1:0] WAIT_LAST = SW'(SLIP_WAIT - 1);

    lock_state_t   state, state_n;
    logic [GW-1:0] good_cnt, good_n;
    logic [WW-1:0] win_cnt, win_n;
    logic [BW-1:0] bad_cnt, bad_n;
    logic [SW-1:0] wait_cnt, wait_n;
    logic          slip_n, up_n;
    logic          frame_good, frame_bad;

    assign frame_good = rx_valid & hdr_is_valid(rx_hdr);
    assign frame_bad  = rx_valid & ~hdr_is_valid(rx_hdr);

    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        win_n   = win_cnt;
        bad_n   = bad_cnt;
        wait_n  = wait_cnt;
        slip_n  = 1'b0;
        up_n    = rx_up;
        case (state)
            ST_HUNT: begin
                up_n = 1'b0;
                if (frame_bad) begin
                    slip_n  = 1'b1;
                    good_n  = '0;
                    wait_n  = '0;
                    state_n = ST_SLIP;
                end else if (frame_good) begin
                    if (good_cnt == GOOD_LAST) begin
                        good_n  = '0;
                        win_n   = '0;
                        bad_n   = '0;
                        up_n    = 1'b1;
                        state_n = ST_LOCKED;
                    end else begin
                        good_n = good_cnt + 1'b1;
                    end
                end
            end
            ST_SLIP: begin
                up_n = 1'b0;
                if (wait_cnt == WAIT_LAST) begin
                    wait_n  = '0;
                    good_n  = '0;
                    state_n = ST_HUNT;
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end
            ST_LOCKED: begin
                // threshold loss wins over the window-end clear on the same frame
                if (frame_bad && bad_cnt == BAD_LAST) begin
                    up_n    = 1'b0;
                    slip_n  = 1'b1;
                    win_n   = '0;
                    bad_n   = '0;
                    wait_n  = '0;
                    state_n = ST_SLIP;
                end else if (rx_valid) begin
                    if (win_cnt == WIN_LAST) begin
                        win_n = '0;
                        bad_n = '0;
                    end else begin
                        win_n = win_cnt + 1'b1;
                        if (frame_bad) bad_n = bad_cnt + 1'b1;
                    end
                end
            end
            default: begin
                up_n    = 1'b0;
                state_n = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_HUNT;
            good_cnt <= '0;
            win_cnt  <= '0;
            bad_cnt  <= '0;
            wait_cnt <= '0;
            rx_slip  <= 1'b0;
            rx_up    <= 1'b0;
        end else begin
            state    <= state_n;
            good_cnt <= good_n;
            win_cnt  <= win_n;
            bad_cnt  <= bad_n;
            wait_cnt <= wait_n;
            rx_slip  <= slip_n;
            rx_up    <= up_n;
        end
    end

    // filter runs only while lock persists, so losing lock clears rx_error with rx_up
    rifl_rx_err_filter #(
        .ERR_CLEAR_CNT(ERR_CLEAR_CNT)
    ) u_err_filter (
        .clk      (clk),
        .rst      (rst),
        .enable   ((state == ST_LOCKED) && (state_n == ST_LOCKED)),
        .crc_valid(rx_valid & rx_crc_valid),
        .crc_good (rx_crc_good),
        .rx_error (rx_error)
    );

endmodule

// File: tb/tb_rifl_rx_lock.sv
// Scoreboard bench for rifl_rx_lock: directed scenarios plus randomized traffic.
module tb_rifl_rx_lock;

    localparam int LOCK_CNT      = 64;
    localparam int WINDOW        = 64;
    localparam int BAD_THRESH    = 16;
    localparam int SLIP_WAIT     = 32;
    localparam int ERR_CLEAR_CNT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [1:0] rx_hdr = 2'b00;
    logic       rx_crc_valid = 1'b0;
    logic       rx_crc_good = 1'b0;
    logic       rx_slip, rx_up, rx_error;

    always #5 clk = ~clk;

    rifl_rx_lock #(
        .LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW), .BAD_THRESH(BAD_THRESH),
        .SLIP_WAIT(SLIP_WAIT), .ERR_CLEAR_CNT(ERR_CLEAR_CNT)
    ) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_hdr(rx_hdr),
        .rx_crc_valid(rx_crc_valid), .rx_crc_good(rx_crc_good),
        .rx_slip(rx_slip), .rx_up(rx_up), .rx_error(rx_error)
    );

    typedef struct packed {
        logic slip;
        logic up;
        logic err;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc_no = 0;

    // reference model: lock status, remaining settle cycles, run lengths
    bit m_locked, m_err, m_slip;
    int m_run, m_blocked, m_win_frames, m_win_bad, m_ok_run;

    task automatic model_step(input bit r, input bit v, input logic [1:0] h,
                              input bit cv, input bit cg);
        bit good_hdr;
        good_hdr = (h == 2'b01) || (h == 2'b10);
        m_slip = 1'b0;
        if (r) begin
            m_locked = 0; m_err = 0; m_run = 0; m_blocked = 0;
            m_win_frames = 0; m_win_bad = 0; m_ok_run = 0;
        end else if (m_blocked > 0) begin
            m_blocked--;
        end else if (!m_locked) begin
            if (v && good_hdr) begin
                m_run++;
                if (m_run == LOCK_CNT) begin
                    m_locked = 1; m_run = 0; m_win_frames = 0; m_win_bad = 0;
                    m_err = 0; m_ok_run = 0;
                end
            end else if (v) begin
                m_slip = 1; m_run = 0; m_blocked = SLIP_WAIT;
            end
        end else if (v) begin
            if (!good_hdr && m_win_bad + 1 == BAD_THRESH) begin
                m_locked = 0; m_slip = 1; m_blocked = SLIP_WAIT;
                m_err = 0; m_ok_run = 0; m_run = 0;
            end else begin
                if (cv) begin
                    if (!cg) begin
                        m_err = 1; m_ok_run = 0;
                    end else if (m_err) begin
                        m_ok_run++;
                        if (m_ok_run == ERR_CLEAR_CNT) begin
                            m_err = 0; m_ok_run = 0;
                        end
                    end
                end
                m_win_frames++;
                if (!good_hdr) m_win_bad++;
                if (m_win_frames == WINDOW) begin
                    m_win_frames = 0; m_win_bad = 0;
                end
            end
        end
    endtask

    task automatic cyc(input bit v, input logic [1:0] h, input bit cv, input bit cg,
                       input bit r = 1'b0);
        exp_t e;
        @(negedge clk);
        rst = r; rx_valid = v; rx_hdr = h; rx_crc_valid = cv; rx_crc_good = cg;
        model_step(r, v, h, cv, cg);
        e.slip = m_slip; e.up = m_locked; e.err = m_err;
        q.push_back(e);
    endtask

    task automatic frames(input int n, input logic [1:0] h, input bit cv = 1'b0,
                          input bit cg = 1'b1);
        for (int i = 0; i < n; i++) cyc(1'b1, h, cv, cg);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    // monitor: every edge the DUT presents a fresh output set
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc_no++;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if ({rx_slip, rx_up, rx_error} !== {e.slip, e.up, e.err}) begin
                    fails++;
                    $display("FAIL outputs cycle %0d slip/up/err got %b%b%b expected %b%b%b",
                             cyc_no, rx_slip, rx_up, rx_error, e.slip, e.up, e.err);
                end
            end
        end
    end

    initial begin
        logic [1:0] bad_hdr;
        int bad_pct;
        // 1: reset then plain lock
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        frames(LOCK_CNT, 2'b01);
        idle(2);
        // 2: slip in HUNT, frames ignored while settling, relock
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        frames(10, 2'b01);
        frames(1, 2'b00);
        frames(SLIP_WAIT, 2'b10);
        frames(LOCK_CNT, 2'b01);
        // 3: 15 bad in a window holds lock; 16 in the next drops it
        frames(15, 2'b11);
        frames(WINDOW - 15, 2'b01);
        frames(16, 2'b00);
        idle(SLIP_WAIT);
        frames(LOCK_CNT, 2'b01);
        frames(15, 2'b11);
        frames(WINDOW - 16, 2'b01);
        frames(1, 2'b00);
        idle(SLIP_WAIT);
        frames(LOCK_CNT, 2'b10);
        // 4: CRC hysteresis with a restart
        frames(1, 2'b01, 1'b1, 1'b0);
        frames(7, 2'b01, 1'b1, 1'b1);
        frames(2, 2'b01, 1'b0, 1'b0);
        frames(1, 2'b01, 1'b1, 1'b0);
        frames(7, 2'b01, 1'b1, 1'b1);
        idle(2);
        frames(1, 2'b01, 1'b1, 1'b1);
        idle(2);
        // 5: error in flight, then loss of lock
        frames(1, 2'b01, 1'b1, 1'b0);
        frames(BAD_THRESH, 2'b11, 1'b1, 1'b0);
        idle(SLIP_WAIT);
        frames(LOCK_CNT, 2'b01);
        idle(2);
        // 6: reset while locked with error
        frames(1, 2'b01, 1'b1, 1'b0);
        cyc(1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
        frames(LOCK_CNT - 1, 2'b01);
        idle(3);
        frames(1, 2'b01);
        idle(2);
        // randomized traffic in blocks of varying header quality
        for (int b = 0; b < 24; b++) begin
            case (b % 4)
                0: bad_pct = 0;
                1: bad_pct = 1;
                2: bad_pct = 4;
                default: bad_pct = 25;
            endcase
            for (int i = 0; i < 300; i++) begin
                bad_hdr = ($urandom_range(1) == 0) ? 2'b00 : 2'b11;
                cyc($urandom_range(99) < 85,
                    ($urandom_range(99) < bad_pct) ? bad_hdr
                        : (($urandom_range(1) == 0) ? 2'b01 : 2'b10),
                    $urandom_range(1) == 1,
                    $urandom_range(99) < 85,
                    $urandom_range(999) == 0);
            end
        end
        idle(1);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
